// File: rtl/sif.sv
// rtl/sif.sv - dual-port X/W register file with a 16-step unsigned multiply-accumulate engine
module sif (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        xa_wr_s,
    input  logic        xa_rd_s,
    input  logic [15:0] xa_addr,
    input  logic [15:0] xa_data_wr,
    output logic [15:0] xa_data_rd,
    input  logic        wa_wr_s,
    input  logic [15:0] wa_addr,
    input  logic [15:0] wa_data_wr
);
    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [15:0] ADDR_CTRL   = 16'h0020;
    localparam logic [15:0] ADDR_STATUS = 16'h0021;
    localparam logic [15:0] ADDR_RES_LO = 16'h0022;
    localparam logic [15:0] ADDR_RES_HI = 16'h0023;

    state_t      state_q;
    logic [15:0] x_q [16];
    logic [15:0] w_q [16];
    logic [31:0] result_q;
    logic [3:0]  idx_q;
    logic        done_q;
    logic [15:0] rd_data_q;
    logic [15:0] rd_data_d;
    logic [31:0] prod_d;
    logic        busy;
    logic        start_d;

    assign busy       = (state_q == RUN);
    assign xa_data_rd = rd_data_q;
    assign prod_d     = {16'h0000, x_q[idx_q]} * {16'h0000, w_q[idx_q]};
    assign start_d    = xa_wr_s && (xa_addr == ADDR_CTRL) && xa_data_wr[0];

    // Read mux sees pre-edge state, so a same-cycle write returns the old value.
    always_comb begin
        rd_data_d = 16'h0000;
        if (xa_addr[15:4] == 12'h000) begin
            rd_data_d = x_q[xa_addr[3:0]];
        end else if (xa_addr[15:4] == 12'h001) begin
            rd_data_d = w_q[xa_addr[3:0]];
        end else begin
            case (xa_addr)
                ADDR_STATUS: rd_data_d = {14'h0000, done_q, busy};
                ADDR_RES_LO: rd_data_d = result_q[15:0];
                ADDR_RES_HI: rd_data_d = result_q[31:16];
                default:     rd_data_d = 16'h0000;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_b) begin
            state_q   <= IDLE;
            result_q  <= 32'h0000_0000;
            idx_q     <= 4'h0;
            done_q    <= 1'b0;
            rd_data_q <= 16'h0000;
            for (int i = 0; i < 16; i++) begin
                x_q[i] <= 16'h0000;
                w_q[i] <= 16'h0000;
            end
        end else begin
            if (xa_rd_s) begin
                rd_data_q <= rd_data_d;
            end
            case (state_q)
                IDLE: begin
                    if (start_d) begin
                        state_q  <= RUN;
                        done_q   <= 1'b0;
                        result_q <= 32'h0000_0000;
                        idx_q    <= 4'h0;
                    end
                    // Array writes are frozen while the engine walks the arrays.
                    if (xa_wr_s && (xa_addr[15:4] == 12'h000)) begin
                        x_q[xa_addr[3:0]] <= xa_data_wr;
                    end
                    if (wa_wr_s && (wa_addr[15:4] == 12'h000)) begin
                        w_q[wa_addr[3:0]] <= wa_data_wr;
                    end
                end
                RUN: begin
                    result_q <= result_q + prod_d;
                    idx_q    <= idx_q + 4'h1;
                    if (idx_q == 4'hF) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sif.sv
// tb/tb_sif.sv - directed self-checking bench for sif
module tb_sif;
    logic        clk;
    logic        rst_b;
    logic        xa_wr_s;
    logic        xa_rd_s;
    logic [15:0] xa_addr;
    logic [15:0] xa_data_wr;
    logic [15:0] xa_data_rd;
    logic        wa_wr_s;
    logic [15:0] wa_addr;
    logic [15:0] wa_data_wr;

    int pass_cnt = 0;
    int total    = 0;

    sif dut (
        .clk        (clk),
        .rst_b      (rst_b),
        .xa_wr_s    (xa_wr_s),
        .xa_rd_s    (xa_rd_s),
        .xa_addr    (xa_addr),
        .xa_data_wr (xa_data_wr),
        .xa_data_rd (xa_data_rd),
        .wa_wr_s    (wa_wr_s),
        .wa_addr    (wa_addr),
        .wa_data_wr (wa_data_wr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic xw(input logic [15:0] a, input logic [15:0] d);
        xa_wr_s = 1'b1; xa_addr = a; xa_data_wr = d;
        tick();
        xa_wr_s = 1'b0;
    endtask

    task automatic ww(input logic [15:0] a, input logic [15:0] d);
        wa_wr_s = 1'b1; wa_addr = a; wa_data_wr = d;
        tick();
        wa_wr_s = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a, output logic [15:0] d);
        xa_rd_s = 1'b1; xa_addr = a;
        tick();
        xa_rd_s = 1'b0;
        d = xa_data_rd;
    endtask

    task automatic test_reset();
        logic [15:0] d;
        rst_b = 1'b1;
        tick();
        xw(16'h0001, 16'h4444);
        rst_b = 1'b0;
        total++;
        if (xa_data_rd !== 16'h0000) $display("FAIL reset_data_rd: got %h want 0000", xa_data_rd);
        else pass_cnt++;
        rd(16'h0000, d); total++;
        if (d !== 16'h0000) $display("FAIL reset_x0: got %h want 0000", d); else pass_cnt++;
        rd(16'h0010, d); total++;
        if (d !== 16'h0000) $display("FAIL reset_w0: got %h want 0000", d); else pass_cnt++;
        rd(16'h0021, d); total++;
        if (d !== 16'h0000) $display("FAIL reset_status: got %h want 0000", d); else pass_cnt++;
        rd(16'h0022, d); total++;
        if (d !== 16'h0000) $display("FAIL reset_result_lo: got %h want 0000", d); else pass_cnt++;
        rd(16'h0001, d); total++;
        if (d !== 16'h0000) $display("FAIL reset_strobe_ignored: got %h want 0000", d); else pass_cnt++;
    endtask

    task automatic test_rw();
        logic [15:0] d;
        xw(16'h0005, 16'hBEEF);
        rd(16'h0005, d); total++;
        if (d !== 16'hBEEF) $display("FAIL rw_x5: got %h want beef", d); else pass_cnt++;
        tick(); total++;
        if (xa_data_rd !== 16'hBEEF) $display("FAIL rw_hold: got %h want beef", xa_data_rd);
        else pass_cnt++;
        rd(16'h0030, d); total++;
        if (d !== 16'h0000) $display("FAIL rw_unmapped: got %h want 0000", d); else pass_cnt++;
        xw(16'h0015, 16'hAAAA);
        rd(16'h0015, d); total++;
        if (d !== 16'h0000) $display("FAIL rw_ro_w5: got %h want 0000", d); else pass_cnt++;
    endtask

    task automatic test_same_cycle_rw();
        logic [15:0] d;
        xa_wr_s = 1'b1; xa_rd_s = 1'b1; xa_addr = 16'h0005; xa_data_wr = 16'h1111;
        tick();
        xa_wr_s = 1'b0; xa_rd_s = 1'b0;
        total++;
        if (xa_data_rd !== 16'hBEEF) $display("FAIL rw_same_old: got %h want beef", xa_data_rd);
        else pass_cnt++;
        rd(16'h0005, d); total++;
        if (d !== 16'h1111) $display("FAIL rw_same_new: got %h want 1111", d); else pass_cnt++;
    endtask

    task automatic test_dual_port();
        logic [15:0] d;
        wa_wr_s = 1'b1; wa_addr = 16'h0003; wa_data_wr = 16'h1234;
        xa_wr_s = 1'b1; xa_addr = 16'h0003; xa_data_wr = 16'h0002;
        tick();
        wa_wr_s = 1'b0; xa_wr_s = 1'b0;
        rd(16'h0013, d); total++;
        if (d !== 16'h1234) $display("FAIL dual_w3: got %h want 1234", d); else pass_cnt++;
        rd(16'h0003, d); total++;
        if (d !== 16'h0002) $display("FAIL dual_x3: got %h want 0002", d); else pass_cnt++;
        ww(16'h0013, 16'h5555);
        rd(16'h0013, d); total++;
        if (d !== 16'h1234) $display("FAIL dual_w_unmapped: got %h want 1234", d); else pass_cnt++;
    endtask

    task automatic test_mac();
        logic [15:0] d;
        for (int i = 0; i < 16; i++) begin
            xa_wr_s = 1'b1; xa_addr = 16'(i); xa_data_wr = 16'(i + 1);
            wa_wr_s = 1'b1; wa_addr = 16'(i); wa_data_wr = 16'h0002;
            tick();
        end
        xa_wr_s = 1'b0; wa_wr_s = 1'b0;
        xw(16'h0020, 16'h0001);
        for (int k = 1; k <= 16; k++) begin
            // A second start mid-run must not restart the engine.
            if (k == 8) begin xa_wr_s = 1'b1; xa_data_wr = 16'h0001; end
            xa_rd_s = 1'b1; xa_addr = (k == 8) ? 16'h0020 : 16'h0021;
            tick();
            xa_rd_s = 1'b0; xa_wr_s = 1'b0;
            if (k != 8) begin
                total++;
                if (xa_data_rd !== 16'h0001) $display("FAIL mac_busy[%0d]: got %h want 0001", k, xa_data_rd);
                else pass_cnt++;
            end
        end
        rd(16'h0021, d); total++;
        if (d !== 16'h0002) $display("FAIL mac_done: got %h want 0002", d); else pass_cnt++;
        rd(16'h0022, d); total++;
        if (d !== 16'h0110) $display("FAIL mac_result_lo: got %h want 0110", d); else pass_cnt++;
        rd(16'h0023, d); total++;
        if (d !== 16'h0000) $display("FAIL mac_result_hi: got %h want 0000", d); else pass_cnt++;
        tick(); tick();
        rd(16'h0021, d); total++;
        if (d !== 16'h0002) $display("FAIL mac_done_sticky: got %h want 0002", d); else pass_cnt++;
    endtask

    task automatic test_overflow();
        logic [15:0] d;
        for (int i = 0; i < 16; i++) begin
            xa_wr_s = 1'b1; xa_addr = 16'(i); xa_data_wr = 16'hFFFF;
            wa_wr_s = 1'b1; wa_addr = 16'(i); wa_data_wr = 16'hFFFF;
            tick();
        end
        xa_wr_s = 1'b0; wa_wr_s = 1'b0;
        xw(16'h0020, 16'h0001);
        for (int k = 0; k < 16; k++) tick();
        rd(16'h0022, d); total++;
        if (d !== 16'h0010) $display("FAIL ovf_result_lo: got %h want 0010", d); else pass_cnt++;
        rd(16'h0023, d); total++;
        if (d !== 16'hFFE0) $display("FAIL ovf_result_hi: got %h want ffe0", d); else pass_cnt++;
    endtask

    task automatic test_abort();
        logic [15:0] d;
        xw(16'h0000, 16'h0007);
        xw(16'h0020, 16'h0001);
        xw(16'h0000, 16'h9999);
        rd(16'h0000, d); total++;
        if (d !== 16'h0007) $display("FAIL abort_busy_write: got %h want 0007", d); else pass_cnt++;
        tick(); tick();
        rst_b = 1'b1;
        tick();
        rst_b = 1'b0;
        total++;
        if (xa_data_rd !== 16'h0000) $display("FAIL abort_data_rd: got %h want 0000", xa_data_rd);
        else pass_cnt++;
        rd(16'h0021, d); total++;
        if (d !== 16'h0000) $display("FAIL abort_status: got %h want 0000", d); else pass_cnt++;
        rd(16'h0022, d); total++;
        if (d !== 16'h0000) $display("FAIL abort_result_lo: got %h want 0000", d); else pass_cnt++;
        rd(16'h0023, d); total++;
        if (d !== 16'h0000) $display("FAIL abort_result_hi: got %h want 0000", d); else pass_cnt++;
        for (int a = 0; a < 32; a++) begin
            rd(16'(a), d); total++;
            if (d !== 16'h0000) $display("FAIL abort_array[%0h]: got %h want 0000", a, d);
            else pass_cnt++;
        end
        tick(); total++;
        if (dut.busy !== 1'b0) $display("FAIL abort_idle: got %b want 0", dut.busy); else pass_cnt++;
    endtask

    initial begin
        rst_b = 1'b1; xa_wr_s = 1'b0; xa_rd_s = 1'b0; xa_addr = 16'h0000;
        xa_data_wr = 16'h0000; wa_wr_s = 1'b0; wa_addr = 16'h0000; wa_data_wr = 16'h0000;
        test_reset();
        test_rw();
        test_same_cycle_rw();
        test_dual_port();
        test_mac();
        test_overflow();
        test_abort();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule

// File: doc/sif.md
SIF -- requirements
Module: sif

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst_b  input  1  synchronous reset, active-high despite the name; sampled on rising clk.
REQ-004 xa_wr_s  input  1  X-port write strobe; one write per cycle while high.
REQ-005 xa_rd_s  input  1  X-port read strobe; one read per cycle while high.
REQ-006 xa_addr  input  16  X-port word address.
REQ-007 xa_data_wr  input  16  X-port write data.
REQ-008 xa_data_rd  output  16  X-port read data, registered.
REQ-009 wa_wr_s  input  1  W-port write strobe; the W port is write-only.
REQ-010 wa_addr  input  16  W-port word address.
REQ-011 wa_data_wr  input  16  W-port write data.

Function
REQ-012 The block SHALL hold two 16x16-bit arrays, X[0..15] and W[0..15], plus a 32-bit accumulator RESULT.
REQ-013 X-port map SHALL be: 0x0000-0x000F X[i] (R/W); 0x0010-0x001F W[i] (read-only); 0x0020 CTRL (W, bit0=start, reads 0); 0x0021 STATUS (R: bit0=busy, bit1=done, others 0); 0x0022 RESULT[15:0] (R); 0x0023 RESULT[31:16] (R).
REQ-014 W-port map SHALL be 0x0000-0x000F -> W[i]; writes to any other W address SHALL be ignored.
REQ-015 X-port writes to unmapped or read-only addresses SHALL be ignored; X-port reads of unmapped addresses SHALL return 0x0000.
REQ-016 Read latency SHALL be 1 cycle: with xa_rd_s high at edge N, xa_data_rd holds the addressed value after edge N and keeps it until the next read.
REQ-017 Same-cycle xa_wr_s and xa_rd_s to the same address SHALL return the old value and commit the write.
REQ-018 Same-cycle X-port write to 0x0010-0x001F is ignored; an X-port write and a W-port write in one cycle SHALL both take effect.
REQ-019 A write to CTRL with bit0=1 while idle SHALL set busy=1, clear done, clear RESULT, and reset the index to 0.
REQ-020 While busy the block SHALL add X[i]*W[i] (unsigned 16x16 -> 32) to RESULT once per cycle for i = 0..15, with modulo-2^32 wrap-around.
REQ-021 After the i=15 accumulation, busy SHALL clear and done SHALL set on the same edge; the total is 16 cycles from the start-write edge.
REQ-022 Start writes while busy SHALL be ignored.
REQ-023 X and W array writes while busy SHALL be ignored; reads remain serviced.
REQ-024 done SHALL stay 1 until the next accepted start or reset.
REQ-025 The state machine SHALL be IDLE -> RUN on accepted start, and RUN -> IDLE after index 15; no other transitions.

Reset
REQ-026 With rst_b high at a rising edge, the block SHALL clear X[], W[], RESULT, index, busy, done and xa_data_rd to 0 and enter IDLE.
REQ-027 Reset asserted mid-RUN SHALL abort the computation with no partial result retained.
REQ-028 Strobes in a cycle where rst_b is high SHALL be ignored.

Verification
REQ-029 Reset, then read 0x0000, 0x0010, 0x0021 and 0x0022 -> each returns 0x0000.
REQ-030 X-port write 0x0005<=0xBEEF, then read 0x0005 -> 0xBEEF one cycle after the read strobe; read 0x0030 -> 0x0000.
REQ-031 W-port write 0x0003<=0x1234 and X-port write 0x0003<=0x0002 in the same cycle -> reads of 0x0013 and 0x0003 return 0x1234 and 0x0002.
REQ-032 Load X[i]=i+1 and W[i]=2, write CTRL=1 -> STATUS=0x0001 for 16 cycles, then 0x0002; RESULT=272 (0x0022=0x0110, 0x0023=0x0000).
REQ-033 Load X[i]=W[i]=0xFFFF for all i and start -> RESULT=16*0xFFFE0001 mod 2^32=0xFFE00010.
REQ-034 Start, then assert rst_b after 5 cycles -> STATUS=0, RESULT=0 and all arrays read 0; a write to X[0] during busy before the reset leaves X[0] unchanged.
